wb_stream_source: RTL and testbench

//  DMA engine, opposite direction to the camera capture path: Wishbone master reads a memory buffer
//  (HyperRAM frame store) and emits it as a 32-bit valid/ready stream (e.g. to a downsizer or a

---
 rtl/wb_stream_source_pkg.sv | 35 +++
 rtl/wb_stream_source_fifo.sv | 49 ++++
 rtl/wb_stream_source.sv | 233 +++++++++++++++++++++++
 tb/tb_wb_stream_source.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_source_pkg.sv
// wb_stream_source shared definitions: register map, CTRL bits, CTI codes, FSM states.
// Optional feature macro: WB_STREAM_SOURCE_BURST_EN (incrementing bursts).
package wb_stream_source_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_IRQ_EN = 3'd1;
  localparam logic [2:0] REG_START  = 3'd2;
  localparam logic [2:0] REG_SIZE   = 3'd3;
  localparam logic [2:0] REG_BURST  = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_ERR   = 2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic        irq_en;
    logic [29:0] start;
    logic [23:0] size;
    logic [4:0]  burst;
  } cfg_t;

endpackage

// File: rtl/wb_stream_source_fifo.sv
// wb_stream_source word FIFO: single clock, push/pop/flush, level output.
// Data output reads as zero while empty so the stream bus idles at 0.
module wb_stream_source_fifo #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wp_q;
  logic [AW:0]   rp_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wp_q == rp_q);
  assign level_o = wp_q - rp_q;
  assign full_o  = level_o[AW];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_stream_source.sv
// wb_stream_source: Wishbone-master DMA reading a buffer out as a 32-bit valid/ready stream.
// Define WB_STREAM_SOURCE_BURST_EN for incrementing bursts; default issues classic single cycles.
module wb_stream_source
  import wb_stream_source_pkg::*;
#(
  parameter int WB_AW     = 32,
  parameter int WB_DW     = 32,
  parameter int FIFO_AW   = 6,
  parameter int MAX_BURST = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic [4:0]       wbs_adr_i,
  input  logic [WB_DW-1:0] wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic [WB_DW-1:0] wbs_dat_o,
  output logic             wbs_ack_o,
  output logic [WB_DW-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             irq_o
);

  localparam int BW = FIFO_AW + 1;
  localparam logic [BW-1:0] MAXB  = BW'(MAX_BURST);
  localparam logic [BW-1:0] DEPTH = BW'(2**FIFO_AW);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [WB_AW-1:0]  addr_q, addr_d;
  logic [23:0]       rem_q, rem_d;
  logic [BW-1:0]     blen_q, blen_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_q;
  logic [WB_DW-1:0]  rdat_q, rdat_d;

  logic              acc, wr, start_req;
  logic [2:0]        sel;
  logic [BW-1:0]     bl_cfg, blen_c, free_c, level;
  logic              cyc, push, flush, done_set, f_empty, f_full;
  logic [2:0]        cti;
  logic              unused_ok;

  assign sel       = wbs_adr_i[4:2];
  assign acc       = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr        = acc & wbs_we_i;
  assign start_req = wr && sel == REG_CTRL && wbs_dat_i[CTRL_START] && !busy_q;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], f_full};

  // Burst length that is reserved in the FIFO before the next bus burst.
  always_comb begin
    bl_cfg = BW'(cfg_q.burst);
    if (cfg_q.burst == '0 || bl_cfg > MAXB) bl_cfg = MAXB;
    blen_c = bl_cfg;
    if (rem_q < 24'(bl_cfg)) blen_c = BW'(rem_q);
    free_c = DEPTH - level;
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    cyc      = 1'b0;
    cti      = CTI_CLASSIC;
    push     = 1'b0;
    flush    = 1'b0;
    done_set = 1'b0;
    if (wr) begin
      unique case (sel)
        REG_CTRL:   if (wbs_dat_i[CTRL_CLR]) done_d = 1'b0;
        REG_IRQ_EN: cfg_d.irq_en = wbs_dat_i[0];
        REG_START:  cfg_d.start = wbs_dat_i[31:2];
        REG_SIZE:   cfg_d.size = wbs_dat_i[23:0];
        REG_BURST:  cfg_d.burst = wbs_dat_i[4:0];
        default:    ;
      endcase
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          err_d = 1'b0;
          if (cfg_q.size == '0) begin
            done_set = 1'b1;
          end else begin
            busy_d  = 1'b1;
            addr_d  = {cfg_q.start, 2'b00};
            rem_d   = cfg_q.size;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (free_c >= blen_c) begin
          blen_d  = blen_c;
          beat_d  = '0;
          gap_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cyc   = ~gap_q;
        gap_d = 1'b0;
`ifdef WB_STREAM_SOURCE_BURST_EN
        cti = (beat_q == blen_q - 1'b1) ? CTI_END : CTI_INCR;
`endif
        if (cyc && wbm_err_i) begin
          flush    = 1'b1;
          err_d    = 1'b1;
          done_set = 1'b1;
          busy_d   = 1'b0;
          rem_d    = '0;
          state_d  = S_IDLE;
        end else if (cyc && wbm_ack_i) begin
          push   = 1'b1;
          addr_d = addr_q + WB_AW'(4);
          rem_d  = rem_q - 1'b1;
          beat_d = beat_q + 1'b1;
`ifndef WB_STREAM_SOURCE_BURST_EN
          gap_d = 1'b1;
`endif
          if (beat_q == blen_q - 1'b1)
            state_d = (rem_q == 24'd1) ? S_DRAIN : S_WAIT;
        end
      end
      S_DRAIN: begin
        if (f_empty) begin
          busy_d   = 1'b0;
          done_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
    // A completion in the same cycle as a write-1-clear keeps the flag set.
    if (done_set) done_d = 1'b1;
  end

  always_comb begin
    rdat_d = '0;
    unique case (sel)
      REG_CTRL:   rdat_d = WB_DW'({err_q, done_q, busy_q});
      REG_IRQ_EN: rdat_d = WB_DW'(cfg_q.irq_en);
      REG_START:  rdat_d = {cfg_q.start, 2'b00};
      REG_SIZE:   rdat_d = WB_DW'(cfg_q.size);
      REG_BURST:  rdat_d = WB_DW'(cfg_q.burst);
      default:    rdat_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      gap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= acc;
      rdat_q  <= (acc && !wbs_we_i) ? rdat_d : '0;
    end
  end

  wb_stream_source_fifo #(
    .AW (FIFO_AW),
    .DW (WB_DW)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n_i),
    .push_i  (push),
    .data_i  (wbm_dat_i),
    .pop_i   (m_ready_i),
    .flush_i (flush),
    .data_o  (m_data_o),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (level)
  );

  assign wbm_adr_o = addr_q;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_dat_o = '0;
  assign wbm_cti_o = cti;
  assign wbm_bte_o = 2'b00;
  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign m_valid_o = ~f_empty;
  assign irq_o     = done_q & cfg_q.irq_en;

endmodule

// File: tb/tb_wb_stream_source.sv
// Self-checking bench for wb_stream_source: random bus/stream timing against a word-count model.
// Works with and without WB_STREAM_SOURCE_BURST_EN.
module tb_wb_stream_source;
  import wb_stream_source_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] madr, mdat_o, mdat = '0, sdat = '0, srd, sdata;
  logic        mcyc, mstb, mwe, mack = 1'b0, merr = 1'b0;
  logic [3:0]  msel, ssel = 4'hF;
  logic [2:0]  mcti;
  logic [1:0]  mbte;
  logic [4:0]  sadr = '0;
  logic        swe = 1'b0, scyc = 1'b0, sstb = 1'b0, sack, svalid, irq;
  logic        sready = 1'b0;

  always #5 clk = ~clk;

  wb_stream_source dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_o(madr), .wbm_cyc_o(mcyc), .wbm_stb_o(mstb), .wbm_we_o(mwe),
    .wbm_sel_o(msel), .wbm_dat_o(mdat_o), .wbm_cti_o(mcti), .wbm_bte_o(mbte),
    .wbm_dat_i(mdat), .wbm_ack_i(mack), .wbm_err_i(merr),
    .wbs_adr_i(sadr), .wbs_dat_i(sdat), .wbs_sel_i(ssel), .wbs_we_i(swe),
    .wbs_cyc_i(scyc), .wbs_stb_i(sstb), .wbs_dat_o(srd), .wbs_ack_o(sack),
    .m_data_o(sdata), .m_valid_o(svalid), .m_ready_i(sready), .irq_o(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Model state: a run streams memf(base + 4*i) for i < size, nothing else.
  logic [31:0] run_base = '0;
  int          run_size = 0, bl_cfg = 16;
  int          fetched = 0, popped = 0, cyc_starts = 0;
  int          beat_in_cyc = 0, cur_blen = 0, beat_cnt = 0;
  int          ack_pct = 80, err_beat = -1, ready_mode = 1;
  logic [31:0] first_word = '0, prev_data = '0;
  logic        prev_cyc = 1'b0, prev_stall = 1'b0, err_pend = 1'b0, err_seen = 1'b0;
  logic [31:0] addr_log[$];

  // Memory slave with random wait states and optional error beat.
  always @(posedge clk) begin
    #1;
    mack = 1'b0;
    merr = 1'b0;
    mdat = '0;
    if (rst_n && mcyc && mstb && $urandom_range(99) < ack_pct) begin
      if (beat_cnt == err_beat) merr = 1'b1;
      else begin
        mack = 1'b1;
        mdat = memf(madr);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sready = 1'b0;
      1:       sready = 1'b1;
      default: sready = ($urandom_range(99) < 60);
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cyc   = 1'b0;
      prev_stall = 1'b0;
      err_pend   = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(svalid), 32'd1);
        chk("stall_data", sdata, prev_data);
      end
      if (svalid && sready) begin
        chk("valid_has_word", 32'(popped < fetched), 32'd1);
        chk("stream_data", sdata, memf(run_base + 32'(popped * 4)));
        if (popped == 0) first_word = sdata;
        popped++;
      end
      if (err_pend) begin
        chk("err_cyc_drop", 32'(mcyc), 32'd0);
        chk("err_flush", 32'(svalid), 32'd0);
        fetched  = popped;
        err_pend = 1'b0;
        err_seen = 1'b1;
      end
      if (mcyc && !prev_cyc) begin
        cyc_starts++;
        beat_in_cyc = 0;
        cur_blen = (run_size - fetched < bl_cfg) ? run_size - fetched : bl_cfg;
      end
      if (mcyc && mstb && merr) begin
        err_pend = 1'b1;
      end else if (mcyc && mstb && mack) begin
        chk("rd_addr", madr, run_base + 32'(fetched * 4));
        chk("bus_const", {25'b0, mwe, msel, mbte}, 32'h3C);
`ifdef WB_STREAM_SOURCE_BURST_EN
        chk("cti", 32'(mcti), (beat_in_cyc == cur_blen - 1) ? 32'd7 : 32'd2);
`else
        chk("cti", 32'(mcti), 32'd0);
        chk("one_word_per_cycle", 32'(beat_in_cyc), 32'd0);
`endif
        addr_log.push_back(madr);
        fetched++;
        beat_cnt++;
        beat_in_cyc++;
      end
      chk("fifo_bound", 32'(fetched - popped <= 64), 32'd1);
      prev_cyc   = mcyc;
      prev_stall = svalid && !sready && !(mcyc && merr);
      prev_data  = sdata;
    end
  end

  task automatic wb_write(logic [2:0] r, logic [31:0] d);
    bit got = 0;
    @(posedge clk); #1;
    scyc = 1'b1; sstb = 1'b1; swe = 1'b1; sadr = {r, 2'b00}; sdat = d;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sack) begin got = 1; break; end
    end
    if (!got) chk("cfg_write_ack", 32'd0, 32'd1);
    scyc = 1'b0; sstb = 1'b0; swe = 1'b0;
  endtask

  task automatic wb_read(logic [2:0] r, output logic [31:0] d);
    bit got = 0;
    d = 'x;
    @(posedge clk); #1;
    scyc = 1'b1; sstb = 1'b1; swe = 1'b0; sadr = {r, 2'b00};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sack) begin got = 1; d = srd; break; end
    end
    if (!got) chk("cfg_read_ack", 32'd0, 32'd1);
    scyc = 1'b0; sstb = 1'b0;
  endtask

  task automatic start_run(logic [31:0] base, int size, int bl);
    wb_write(REG_START, base);
    wb_write(REG_SIZE, 32'(size));
    wb_write(REG_BURST, 32'(bl));
    run_base   = base;
    run_size   = size;
    bl_cfg     = (bl == 0 || bl > 16) ? 16 : bl;
    fetched    = 0;
    popped     = 0;
    cyc_starts = 0;
    beat_cnt   = 0;
    addr_log.delete();
    wb_write(REG_CTRL, 32'd1);
  endtask

  task automatic wait_done(int maxr);
    logic [31:0] v;
    bit ok = 0;
    for (int i = 0; i < maxr; i++) begin
      wb_read(REG_CTRL, v);
      if (v[CTRL_BUSY] === 1'b0) begin ok = 1; break; end
    end
    chk("done_in_time", 32'(ok), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    #3;
    chk("rst_cyc", 32'(mcyc), 32'd0);
    chk("rst_valid", 32'(svalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_adr", madr, 32'd0);
    chk("rst_data", sdata, 32'd0);
    chk("model_pin", memf(32'h100), 32'h1334_A887);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wb_read(REG_CTRL, v);
    chk("rst_ctrl", v, 32'd0);

    // Two bursts of four, stream always ready.
    wb_write(REG_IRQ_EN, 32'd1);
    ready_mode = 1;
    start_run(32'h100, 8, 4);
    wait_done(500);
    chk("t1_fetched", 32'(fetched), 32'd8);
    chk("t1_popped", 32'(popped), 32'd8);
`ifdef WB_STREAM_SOURCE_BURST_EN
    chk("t1_bursts", 32'(cyc_starts), 32'd2);
`else
    chk("t1_cycles", 32'(cyc_starts), 32'd8);
`endif
    chk("t1_first", first_word, 32'h1334_A887);
    wb_read(REG_CTRL, v);
    chk("t1_ctrl", v, 32'h2);
    chk("t1_irq", 32'(irq), 32'd1);

    wb_write(REG_CTRL, 32'h2);
    wb_read(REG_CTRL, v);
    chk("w1c_ctrl", v, 32'h0);
    chk("w1c_irq", 32'(irq), 32'd0);

    // Backpressure: FIFO fills to its depth, then the master idles.
    ready_mode = 0;
    start_run(32'h1000, 100, 0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("hold_fetched", 32'(fetched), 32'd64);
    chk("hold_cyc", 32'(mcyc), 32'd0);
    chk("hold_valid", 32'(svalid), 32'd1);
    ready_mode = 2;
    wait_done(3000);
    chk("hold_popped", 32'(popped), 32'd100);
    chk("hold_irq", 32'(irq), 32'd1);

    // Address wrap at the top of the 32-bit space.
    ready_mode = 1;
    start_run(32'hFFFF_FFF8, 4, 4);
    wait_done(500);
    chk("wrap_n", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", addr_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", addr_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", addr_log[2], 32'h0000_0000);
      chk("wrap_a3", addr_log[3], 32'h0000_0004);
    end

    for (int k = 0; k < 5; k++) begin
      int sz, bl;
      sz = $urandom_range(150, 1);
      bl = $urandom_range(16, 0);
      ack_pct = $urandom_range(100, 40);
      ready_mode = 2;
      start_run($urandom & 32'hFFFF_FFFC, sz, bl);
      wait_done(3000);
      chk("rand_fetched", 32'(fetched), 32'(sz));
      chk("rand_popped", 32'(popped), 32'(sz));
    end
    ack_pct = 80;

    // Bus error on the third beat.
    err_beat = 2;
    err_seen = 1'b0;
    start_run(32'h2000, 20, 8);
    wait_done(500);
    wb_read(REG_CTRL, v);
    chk("err_ctrl", v, 32'h6);
    chk("err_seen", 32'(err_seen), 32'd1);
    chk("err_valid", 32'(svalid), 32'd0);
    err_beat = -1;
    start_run(32'h3000, 3, 2);
    wait_done(500);
    wb_read(REG_CTRL, v);
    chk("err_cleared", v, 32'h2);

    // Zero-length start.
    wb_write(REG_CTRL, 32'h2);
    start_run(32'h5000, 0, 4);
    wb_read(REG_CTRL, v);
    chk("zero_ctrl", v, 32'h2);
    repeat (10) @(posedge clk);
    chk("zero_no_bus", 32'(cyc_starts), 32'd0);

    // Start while busy must not restart the transfer.
    ready_mode = 2;
    start_run(32'h4000, 60, 4);
    repeat (20) @(posedge clk);
    wb_write(REG_START, 32'h9000);
    wb_write(REG_CTRL, 32'd1);
    wait_done(3000);
    chk("busy_fetched", 32'(fetched), 32'd60);
    chk("busy_popped", 32'(popped), 32'd60);

    // Reset during a burst.
    start_run(32'h8000, 200, 8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mcyc) break;
    end
    chk("mid_cyc_seen", 32'(mcyc), 32'd1);
    chk("mid_irq_before", 32'(irq), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(mcyc), 32'd0);
    chk("mid_rst_stb", 32'(mstb), 32'd0);
    chk("mid_rst_valid", 32'(svalid), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    run_size = 0;
    fetched  = 0;
    popped   = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read(REG_CTRL, v);
    chk("mid_ctrl", v, 32'd0);
    wb_read(REG_IRQ_EN, v);
    chk("mid_irqen", v, 32'd0);
    wb_read(REG_START, v);
    chk("mid_start", v, 32'd0);
    wb_read(REG_SIZE, v);
    chk("mid_size", v, 32'd0);
    wb_read(REG_BURST, v);
    chk("mid_burst", v, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
